// File: rtl/pdu_input_frontend.sv
`default_nettype none
// ============================================================================
// Module   : pdu_input_frontend
// Brief    : Debounces the PDU push-buttons and slide switches; switch toggles
//            become hex-digit entries into a 32-bit data-move register.
// Revision : 1.0 - initial release
// ============================================================================
module pdu_input_frontend #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] sw,
   input  logic        butu,
   input  logic        butd,
   input  logic        butr,
   input  logic        butc,
   input  logic        butl,
   input  logic [31:0] din,
   input  logic        set,
   output logic        del,
   output logic        cont,
   output logic        chk_r,
   output logic        data,
   output logic        chk_l,
   output logic [3:0]  hex,
   output logic        pulse,
   output logic [31:0] dout
);

   localparam int c_NUM_BTN = 5;
   localparam int c_NUM_SW  = 16;
   localparam int c_NUM_IN  = c_NUM_BTN + c_NUM_SW;
   localparam int c_CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEB_CYCLES - 1);

   // Buttons occupy the low five cells, switches the upper sixteen.
   logic [c_NUM_IN-1:0]  w_raw;
   logic [c_NUM_IN-1:0]  w_lvl;
   logic [c_NUM_IN-1:0]  r_lvl_d;
   logic [c_NUM_BTN-1:0] w_btn_rise;
   logic [c_NUM_BTN-1:0] r_btn_pulse;
   logic [c_NUM_SW-1:0]  w_sw_chg;
   logic [3:0]           w_hex;
   logic [3:0]           r_hex;
   logic                 r_pulse;
   logic [31:0]          r_dout;

   assign w_raw = {sw, butl, butc, butr, butd, butu};

   generate
      for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_deb
         logic            r_s1;
         logic            r_s2;
         logic            r_lvl;
         logic [c_CW-1:0] r_cnt;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_s1  <= 1'b0;
               r_s2  <= 1'b0;
               r_lvl <= 1'b0;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_lvl) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_lvl <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_lvl[gi] = r_lvl;
      end
   endgenerate

   assign w_btn_rise = w_lvl[c_NUM_BTN-1:0] & ~r_lvl_d[c_NUM_BTN-1:0];
   assign w_sw_chg   = w_lvl[c_NUM_IN-1:c_NUM_BTN] ^ r_lvl_d[c_NUM_IN-1:c_NUM_BTN];

   // Descending scan so the lowest changed index wins.
   always_comb begin
      w_hex = 4'h0;
      for (int i = c_NUM_SW - 1; i >= 0; i--) begin
         if (w_sw_chg[i]) begin
            w_hex = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_lvl_d     <= '0;
         r_btn_pulse <= '0;
         r_pulse     <= 1'b0;
         r_hex       <= 4'h0;
      end else begin
         r_lvl_d     <= w_lvl;
         r_btn_pulse <= w_btn_rise;
         r_pulse     <= |w_sw_chg;
         if (|w_sw_chg) begin
            r_hex <= w_hex;
         end
      end
   end

   // Coinciding lower-priority events are dropped, not queued.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dout <= 32'h0;
      end else if (set) begin
         r_dout <= din;
      end else if (r_pulse) begin
         r_dout <= {r_dout[27:0], r_hex};
      end else if (r_btn_pulse[0]) begin
         r_dout <= {4'h0, r_dout[31:4]};
      end
   end

   assign del   = r_btn_pulse[0];
   assign cont  = r_btn_pulse[1];
   assign chk_r = r_btn_pulse[2];
   assign data  = r_btn_pulse[3];
   assign chk_l = r_btn_pulse[4];
   assign hex   = r_hex;
   assign pulse = r_pulse;
   assign dout  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_pdu_input_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdu_input_frontend
// Brief    : Directed self-checking bench for pdu_input_frontend, DEB_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdu_input_frontend;

   localparam int DEB = 4;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] sw   = '0;
   logic        butu = 1'b0, butd = 1'b0, butr = 1'b0, butc = 1'b0, butl = 1'b0;
   logic [31:0] din  = '0;
   logic        set  = 1'b0;
   logic        del, cont, chk_r, data, chk_l, pulse;
   logic [3:0]  hex;
   logic [31:0] dout;

   int total = 0;
   int bad   = 0;
   int n_pulse = 0, n_cont = 0, n_del = 0, n_any = 0;
   int p0;

   pdu_input_frontend #(.DEB_CYCLES(DEB)) dut (
      .clk(clk), .rstn(rstn), .sw(sw),
      .butu(butu), .butd(butd), .butr(butr), .butc(butc), .butl(butl),
      .din(din), .set(set),
      .del(del), .cont(cont), .chk_r(chk_r), .data(data), .chk_l(chk_l),
      .hex(hex), .pulse(pulse), .dout(dout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pulse) n_pulse++;
      if (cont)  n_cont++;
      if (del)   n_del++;
      if (pulse | del | cont | chk_r | data | chk_l) n_any++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Strobe is visible 7 negedges after driving, dout one cycle later.
   task automatic toggle_sw(input int idx, input logic [3:0] eh, input logic [31:0] ed);
      int q0;
      q0 = n_pulse;
      sw[idx] = ~sw[idx];
      cyc(7);
      chk("sw_pulse", {31'b0, pulse}, 32'd1);
      chk("sw_hex", {28'b0, hex}, {28'b0, eh});
      cyc(5);
      chk("sw_dout", dout, ed);
      chk("sw_npulse", n_pulse - q0, 32'd1);
   endtask

   initial begin
      rstn = 1'b0;
      sw = 16'hFFFF; butu = 1; butd = 1; butr = 1; butc = 1; butl = 1;
      set = 1'b1; din = 32'hFFFF_FFFF;
      cyc(3);
      chk("rst_dout", dout, 32'h0);
      chk("rst_hex", {28'b0, hex}, 32'h0);
      chk("rst_strobes", {26'b0, del, cont, chk_r, data, chk_l, pulse}, 32'h0);
      sw = '0; butu = 0; butd = 0; butr = 0; butc = 0; butl = 0;
      set = 1'b0; din = '0;
      cyc(3);
      rstn = 1'b1;
      cyc(20);
      chk("post_rst_strobes", n_any, 32'd0);
      chk("post_rst_dout", dout, 32'h0);

      butd = 1'b1;
      cyc(3);
      butd = 1'b0;
      cyc(15);
      chk("glitch_cont", n_cont, 32'd0);

      butd = 1'b1;
      cyc(6);
      chk("cont_early", {31'b0, cont}, 32'd0);
      cyc(1);
      chk("cont_pulse", {31'b0, cont}, 32'd1);
      cyc(1);
      chk("cont_one", {31'b0, cont}, 32'd0);
      cyc(20);
      chk("cont_held", n_cont, 32'd1);
      butd = 1'b0;
      cyc(15);
      chk("cont_release", n_cont, 32'd1);
      chk("cont_dout", dout, 32'h0);

      toggle_sw(10, 4'hA, 32'h0000_000A);
      toggle_sw(3,  4'h3, 32'h0000_00A3);
      toggle_sw(15, 4'hF, 32'h0000_0A3F);
      toggle_sw(3,  4'h3, 32'h0000_A3F3);

      set = 1'b1; din = 32'h1234_5678;
      cyc(1);
      set = 1'b0;
      chk("set_load", dout, 32'h1234_5678);
      toggle_sw(9, 4'h9, 32'h2345_6789);

      butu = 1'b1;
      cyc(7);
      chk("del_pulse", {31'b0, del}, 32'd1);
      cyc(1);
      chk("del_dout", dout, 32'h0234_5678);
      cyc(5);
      butu = 1'b0;
      cyc(15);
      chk("del_release", dout, 32'h0234_5678);
      chk("del_count", n_del, 32'd1);

      sw[5] = 1'b1;
      cyc(7);
      chk("prio_pulse", {31'b0, pulse}, 32'd1);
      chk("prio_hex", {28'b0, hex}, 32'h5);
      set = 1'b1; din = 32'hDEAD_BEEF;
      cyc(1);
      set = 1'b0;
      chk("prio_set", dout, 32'hDEAD_BEEF);
      cyc(3);
      chk("prio_set_hold", dout, 32'hDEAD_BEEF);

      butu = 1'b1;
      sw[1] = 1'b1;
      cyc(7);
      chk("pd_del", {31'b0, del}, 32'd1);
      chk("pd_pulse", {31'b0, pulse}, 32'd1);
      chk("pd_hex", {28'b0, hex}, 32'h1);
      cyc(1);
      chk("pd_dout", dout, 32'hEADB_EEF1);
      cyc(3);
      butu = 1'b0;
      cyc(15);
      chk("pd_dout_hold", dout, 32'hEADB_EEF1);

      p0 = n_pulse;
      sw = sw | 16'h0084;
      cyc(7);
      chk("simul_hex", {28'b0, hex}, 32'h2);
      cyc(5);
      chk("simul_npulse", n_pulse - p0, 32'd1);
      chk("simul_dout", dout, 32'hADBE_EF12);

      rstn = 1'b0;
      cyc(2);
      chk("rst2_dout", dout, 32'h0);
      p0 = n_pulse;
      rstn = 1'b1;
      cyc(12);
      chk("rst2_npulse", n_pulse - p0, 32'd1);
      chk("rst2_hex", {28'b0, hex}, 32'h1);
      chk("rst2_dout", dout, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pdu_input_frontend.md
# pdu_input_frontend

Operator-input front end of the PDU. It debounces the five push-buttons into single-cycle press pulses. It also debounces the 16 slide switches and turns each switch toggle into a hex-digit entry pulse. A 32-bit data-move register collects those digits, supports deleting the last digit, and can be loaded in parallel by the PDU controller.

## Interface
- `DEB_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a new input level (10 ms at 100 MHz). Legal range ≥1.
- `clk`  in  1  system clock (100 MHz); all state on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `sw`  in  16  raw slide switches, asynchronous.
- `butu`, `butd`, `butr`, `butc`, `butl`  in  1 each  raw push-buttons, asynchronous, active-high.
- `din`  in  32  parallel load value for the data-move register.
- `set`  in  1  synchronous load strobe: `dout <= din`.
- `del`, `cont`, `chk_r`, `data`, `chk_l`  out  1 each  one-cycle press pulses for `butu`, `butd`, `butr`, `butc`, `butl` respectively.
- `hex`  out  4  index (0–15) of the most recently toggled switch.
- `pulse`  out  1  one-cycle strobe marking a switch toggle; `hex` is valid in the same cycle.
- `dout`  out  32  data-move register contents.

## Operation
- **Per-input debounce cell.** There are 21 cells: 5 buttons and 16 switches.
  - Two-flop synchronizer `s1`→`s2`, then a debounced level `lvl` and a counter `cnt`.
  - Each edge where `s2 != lvl`: `cnt` increments. On the DEB_CYCLES-th consecutive differing edge, `lvl <= s2` and `cnt` clears.
  - Any edge where `s2 == lvl` clears `cnt`, so a glitch shorter than DEB_CYCLES samples is ignored.
- **Buttons.**
  - The output pulse is registered and asserts for exactly 1 cycle, in the cycle after `lvl` goes 0→1.
  - A release (1→0) produces no pulse. Holding a button yields one pulse only.
- **Switches.**
  - A toggle in either direction (any `lvl` bit change) produces one registered `pulse` cycle.
  - `hex` is registered with that pulse and holds its value until the next toggle.
  - If several switch levels change on the same edge, `hex` takes the lowest changed index and only one pulse is issued.
- **Data-move register**, priority `set` > `pulse` > `del` within one edge:
  - `set`: `dout <= din`.
  - `pulse`: `dout <= {dout[27:0], hex}`, shift left one nibble and append the digit; the top nibble is discarded.
  - `del` (internal debounced `butu`): `dout <= {4'h0, dout[31:4]}`, removing the last digit.
  - Otherwise `dout` holds its value.
  - A lower-priority event that coincides with a higher one is dropped, not deferred.
- **Reset.**
  - All synchronizers, levels, counters, pulses, `hex` and `dout` clear to 0.
  - A reset assertion mid-count discards the count.
  - A switch already high at reset release is treated as a 0→1 toggle and produces one pulse after debounce.

## Timing
- Latency for a raw input change first sampled at edge 0:
  - `s2` updates at edge 1.
  - `lvl` updates at edge DEB_CYCLES+1.
  - The pulse output is high during the cycle following edge DEB_CYCLES+2.
  - This latency applies equally to `del`/`cont`/`chk_r`/`data`/`chk_l` and to `pulse`.
- `dout` reflects a `pulse` or `del` at the edge after the strobe, i.e. edge DEB_CYCLES+3.
- `set` takes effect at the first edge where it is sampled high. It is level-sensitive, so holding it high reloads every cycle.
- Outputs are glitch-free because all of them are registered.

## Test plan
All scenarios use DEB_CYCLES=4.
- **Reset.** Assert `rstn`=0 with arbitrary inputs. Required: all outputs are 0, and stay 0 for 20 cycles after release with inputs low.
- **Button debounce.**
  - Raise `butd` for 3 cycles, then drop it: `cont` never pulses.
  - Hold `butd` high: `cont` is high for exactly 1 cycle, 6 cycles after the first sampling edge, then never again while held; release produces no pulse.
- **Digit entry.**
  - From `dout`=0, toggle `sw[10]` then `sw[3]` then `sw[15]`, each stable for at least 10 cycles. Required: three single-cycle `pulse`es with `hex`=A, 3, F; final `dout`=0x0000_0A3F.
  - Toggling `sw[3]` back low appends another 3, giving 0x0000_A3F3.
- **Delete and overflow.**
  - Start from `dout`=0x1234_5678 via `set`. Enter digit 9: `dout`=0x2345_6789.
  - Then press `butu`: `dout`=0x0234_5678.
- **Priority.**
  - Assert `set` with `din`=0xDEAD_BEEF in the same cycle as `pulse`: `dout`=0xDEAD_BEEF and the digit is lost.
  - `pulse` coinciding with `del`: only the shift-in occurs.
- **Simultaneous switches.** Flip `sw[7]` and `sw[2]` on the same cycle. Required: one `pulse` with `hex`=2.
